// File: rtl/mul_req_scheduler_pkg.sv
// Shared definitions for the multiplier request scheduler: FSM encoding and
// a width helper used to size the requester index.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Bits needed to hold an index in 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_req_scheduler_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic w_found;
  int   w_j;

  // Scan requesters starting from the pointer and stop at the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IDW'(w_j);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_req_scheduler.sv
// Shares one sequential multiplier among NREQ requesters. Grants round-robin,
// captures operands, pulses start, waits for done (guarded by a watchdog) and
// returns the product with the requester id on a valid/ready channel.
// Zero operands bypass the multiplier entirely.
module mul_req_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  localparam int IDW    = clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*W-1:0] i_req_a,
  input  logic [NREQ*W-1:0] i_req_b,
  output logic              o_mul_start,
  output logic [W-1:0]      o_mul_a,
  output logic [W-1:0]      o_mul_b,
  input  logic              i_mul_done,
  input  logic [2*W-1:0]    i_mul_product,
  output logic              o_mul_abort,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [2*W-1:0]    o_rsp_product,
  output logic              o_rsp_err,
  input  logic              i_rsp_ready,
  output logic              o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IDW-1:0] r_id;
  logic [2*W-1:0] r_product;
  logic           r_err;
  logic [CW-1:0]  r_cnt;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_zero;
  logic            w_expire;
  logic [IDW-1:0]  w_ptr_next;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_sel_a    = i_req_a[int'(w_idx)*W +: W];
  assign w_sel_b    = i_req_b[int'(w_idx)*W +: W];
  assign w_zero     = (w_sel_a == '0) || (w_sel_b == '0);
  assign w_expire   = (r_cnt == CW'(TIMEOUT - 1)) && !i_mul_done;
  assign w_ptr_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

  assign o_mul_a       = r_a;
  assign o_mul_b       = r_b;
  assign o_rsp_id      = r_id;
  assign o_rsp_product = r_product;
  assign o_rsp_err     = r_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic; mul_done beats a simultaneous watchdog expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_any) w_next_state = w_zero ? RESP : ISSUE;
      ISSUE: w_next_state = WAIT;
      WAIT:  if (i_mul_done || w_expire) w_next_state = RESP;
      RESP:  if (i_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    o_req_ready = '0;
    o_mul_start = 1'b0;
    o_mul_abort = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:  if (i_reset_n) o_req_ready = w_grant;
      ISSUE: o_mul_start = 1'b1;
      WAIT:  o_mul_abort = w_expire;
      RESP:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture, pointer, watchdog and response registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_id  <= w_idx;
            r_ptr <= w_ptr_next;
            if (w_zero) begin
              r_product <= '0;
              r_err     <= 1'b0;
            end
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (i_mul_done) begin
            r_product <= i_mul_product;
            r_err     <= 1'b0;
          end else if (w_expire) begin
            r_product <= '0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
